// File: rtl/multicycle_controller.sv
// Multi-cycle CPU control FSM: sequences fetch, decode, execute, memory and
// writeback over a shared ALU and unified memory. Memory states stall on
// mem_ready, and a wait of TIMEOUT cycles or an unknown opcode parks the
// machine in ILLEGAL with a sticky fault until reset.
module multicycle_controller #(
  parameter int         TIMEOUT  = 16,
  parameter logic [5:0] JR_FUNCT = 6'b001000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] opcode,
  input  logic [5:0] functi,
  input  logic       zero,
  input  logic       mem_ready,
  output logic       pc_write,
  output logic       instr_or_data,
  output logic       mem_read,
  output logic       memory_write,
  output logic       ir_write,
  output logic [1:0] memory_to_register,
  output logic [1:0] register_destination,
  output logic       register_write,
  output logic       alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [1:0] alu_operation,
  output logic [1:0] pc_source,
  output logic       fault,
  output logic [3:0] state
);

  localparam int CW = $clog2(TIMEOUT) + 1;

  typedef enum logic [3:0] {
    FETCH   = 4'd0,
    DECODE  = 4'd1,
    MEMADR  = 4'd2,
    MEMRD   = 4'd3,
    MEMWB   = 4'd4,
    MEMWR   = 4'd5,
    EXEC_R  = 4'd6,
    RWB     = 4'd7,
    EXEC_I  = 4'd8,
    EXEC_SI = 4'd9,
    IWB     = 4'd10,
    BRANCH  = 4'd11,
    JUMP    = 4'd12,
    JAL     = 4'd13,
    JR      = 4'd14,
    ILLEGAL = 4'd15
  } state_t;

  state_t         st, nxt;
  logic [CW-1:0]  cnt;
  logic           fault_q;
  logic           waiting;
  logic           expired;

  // States that wait on the memory handshake and are subject to the timeout.
  assign waiting = (st == FETCH) || (st == MEMRD) || (st == MEMWR);
  // Last permitted wait cycle: cnt counts cycles already spent without ready.
  assign expired = (cnt == CW'(TIMEOUT - 1));

  assign state = st;
  assign fault = fault_q;

  // State register.
  always_ff @(posedge clk) begin
    if (reset) st <= FETCH;
    else       st <= nxt;
  end

  // Wait counter: restarts whenever the state changes, counts stalled cycles.
  always_ff @(posedge clk) begin
    if (reset)                      cnt <= '0;
    else if (nxt != st)             cnt <= '0;
    else if (waiting && !mem_ready) cnt <= cnt + 1'b1;
  end

  // Sticky fault: set on any transition into ILLEGAL, cleared only by reset.
  always_ff @(posedge clk) begin
    if (reset)              fault_q <= 1'b0;
    else if (nxt == ILLEGAL) fault_q <= 1'b1;
  end

  // Next-state and control decode; every output defaults to inactive.
  always_comb begin
    nxt                  = st;
    pc_write             = 1'b0;
    instr_or_data        = 1'b0;
    mem_read             = 1'b0;
    memory_write         = 1'b0;
    ir_write             = 1'b0;
    memory_to_register   = 2'b00;
    register_destination = 2'b00;
    register_write       = 1'b0;
    alu_src_a            = 1'b0;
    alu_src_b            = 2'b00;
    alu_operation        = 2'b00;
    pc_source            = 2'b00;
    case (st)
      FETCH: begin
        mem_read  = 1'b1;
        alu_src_b = 2'b01;
        if (mem_ready) begin
          ir_write = 1'b1;
          pc_write = 1'b1;
          nxt      = DECODE;
        end else if (expired) begin
          nxt = ILLEGAL;
        end
      end
      DECODE: begin
        // Precompute the branch target into ALUOut while dispatching.
        alu_src_b = 2'b11;
        case (opcode)
          6'b000000: nxt = (functi == JR_FUNCT) ? JR : EXEC_R;
          6'b000001,
          6'b000010: nxt = MEMADR;
          6'b000011: nxt = EXEC_I;
          6'b000100: nxt = EXEC_SI;
          6'b000101: nxt = BRANCH;
          6'b000111: nxt = JUMP;
          6'b001000: nxt = JAL;
          default:   nxt = ILLEGAL;
        endcase
      end
      MEMADR: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
        nxt       = (opcode == 6'b000001) ? MEMRD : MEMWR;
      end
      MEMRD: begin
        mem_read      = 1'b1;
        instr_or_data = 1'b1;
        if (mem_ready)    nxt = MEMWB;
        else if (expired) nxt = ILLEGAL;
      end
      MEMWB: begin
        register_write     = 1'b1;
        memory_to_register = 2'b01;
        nxt                = FETCH;
      end
      MEMWR: begin
        memory_write  = 1'b1;
        instr_or_data = 1'b1;
        if (mem_ready)    nxt = FETCH;
        else if (expired) nxt = ILLEGAL;
      end
      EXEC_R: begin
        alu_src_a     = 1'b1;
        alu_operation = 2'b10;
        nxt           = RWB;
      end
      RWB: begin
        register_write       = 1'b1;
        register_destination = 2'b01;
        nxt                  = FETCH;
      end
      EXEC_I: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
        nxt       = IWB;
      end
      EXEC_SI: begin
        alu_src_a     = 1'b1;
        alu_src_b     = 2'b10;
        alu_operation = 2'b01;
        nxt           = IWB;
      end
      IWB: begin
        register_write = 1'b1;
        nxt            = FETCH;
      end
      BRANCH: begin
        alu_src_a     = 1'b1;
        alu_operation = 2'b01;
        pc_source     = 2'b01;
        pc_write      = zero;
        nxt           = FETCH;
      end
      JUMP: begin
        pc_source = 2'b10;
        pc_write  = 1'b1;
        nxt       = FETCH;
      end
      JAL: begin
        // PC already holds PC+4 from fetch, so it is the link value.
        pc_source            = 2'b10;
        pc_write             = 1'b1;
        register_write       = 1'b1;
        register_destination = 2'b10;
        memory_to_register   = 2'b10;
        nxt                  = FETCH;
      end
      JR: begin
        pc_source = 2'b11;
        pc_write  = 1'b1;
        nxt       = FETCH;
      end
      ILLEGAL: nxt = ILLEGAL;
      default: nxt = ILLEGAL;
    endcase
  end

endmodule

// File: tb/tb_multicycle_controller.sv
// Bench for multicycle_controller: each instruction is expanded into the
// expected sequence of states (with stall lengths chosen up front), then
// replayed cycle by cycle while state, controls and fault are compared.
module tb_multicycle_controller;

  logic       clk = 1'b0;
  logic       reset;
  logic [5:0] opcode, functi;
  logic       zero, mem_ready;
  logic       pc_write, instr_or_data, mem_read, memory_write, ir_write;
  logic [1:0] memory_to_register, register_destination;
  logic       register_write, alu_src_a;
  logic [1:0] alu_src_b, alu_operation, pc_source;
  logic       fault;
  logic [3:0] state;

  multicycle_controller dut (
    .clk(clk), .reset(reset), .opcode(opcode), .functi(functi),
    .zero(zero), .mem_ready(mem_ready), .pc_write(pc_write),
    .instr_or_data(instr_or_data), .mem_read(mem_read),
    .memory_write(memory_write), .ir_write(ir_write),
    .memory_to_register(memory_to_register),
    .register_destination(register_destination),
    .register_write(register_write), .alu_src_a(alu_src_a),
    .alu_src_b(alu_src_b), .alu_operation(alu_operation),
    .pc_source(pc_source), .fault(fault), .state(state)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;

  wire [16:0] ctrl = {pc_write, instr_or_data, mem_read, memory_write, ir_write,
                      memory_to_register, register_destination, register_write,
                      alu_src_a, alu_src_b, alu_operation, pc_source};

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Control word the specification lists for each state code.
  function automatic logic [16:0] exp_ctrl(input int s, input logic rdy, input logic z);
    logic pw, iod, mr, mw, irw, rw, asa;
    logic [1:0] m2r, rd, asb, aop, ps;
    {pw, iod, mr, mw, irw, rw, asa} = '0;
    {m2r, rd, asb, aop, ps} = '0;
    case (s)
      0:  begin mr = 1; asb = 2'b01; pw = rdy; irw = rdy; end
      1:  asb = 2'b11;
      2:  begin asa = 1; asb = 2'b10; end
      3:  begin mr = 1; iod = 1; end
      4:  begin rw = 1; m2r = 2'b01; end
      5:  begin mw = 1; iod = 1; end
      6:  begin asa = 1; aop = 2'b10; end
      7:  begin rw = 1; rd = 2'b01; end
      8:  begin asa = 1; asb = 2'b10; end
      9:  begin asa = 1; asb = 2'b10; aop = 2'b01; end
      10: rw = 1;
      11: begin asa = 1; aop = 2'b01; ps = 2'b01; pw = z; end
      12: begin ps = 2'b10; pw = 1; end
      13: begin ps = 2'b10; pw = 1; rw = 1; rd = 2'b10; m2r = 2'b10; end
      14: begin ps = 2'b11; pw = 1; end
      default: ;
    endcase
    return {pw, iod, mr, mw, irw, m2r, rd, rw, asa, asb, aop, ps};
  endfunction

  // Expected path: state per cycle and the mem_ready to drive (2 = random).
  int pq[$];
  int rq[$];

  // Wait state with n stalled cycles; n >= 16 runs out the timeout.
  task automatic add_wait(input int s, input int n, output bit dead);
    dead = (n >= 16);
    for (int i = 0; i < (dead ? 16 : n); i++) begin pq.push_back(s); rq.push_back(0); end
    if (dead) begin pq.push_back(15); rq.push_back(2); end
    else      begin pq.push_back(s);  rq.push_back(1); end
  endtask

  task automatic push(input int s);
    pq.push_back(s); rq.push_back(2);
  endtask

  // zsel: 0/1 forces zero, 2 randomizes it each cycle.
  task automatic run_instr(input logic [5:0] op, input logic [5:0] fn,
                           input int fw, input int mw, input int zsel);
    bit dead;
    logic r, z;
    pq.delete(); rq.delete();
    add_wait(0, fw, dead);
    if (!dead) begin
      push(1);
      case (op)
        6'd0: if (fn == 6'b001000) push(14); else begin push(6); push(7); end
        6'd1: begin push(2); add_wait(3, mw, dead); if (!dead) push(4); end
        6'd2: begin push(2); add_wait(5, mw, dead); end
        6'd3: begin push(8); push(10); end
        6'd4: begin push(9); push(10); end
        6'd5: push(11);
        6'd7: push(12);
        6'd8: push(13);
        default: push(15);
      endcase
    end
    foreach (pq[i]) begin
      @(negedge clk);
      r = (rq[i] == 2) ? 1'($urandom) : 1'(rq[i]);
      z = (zsel == 2) ? 1'($urandom) : 1'(zsel);
      opcode = op; functi = fn; mem_ready = r; zero = z;
      #1;
      chk($sformatf("state op=%0h i=%0d", op, i), 32'(state), 32'(pq[i]));
      chk($sformatf("ctrl op=%0h s=%0d", op, pq[i]), 32'(ctrl), 32'(exp_ctrl(pq[i], r, z)));
      chk($sformatf("fault op=%0h s=%0d", op, pq[i]), 32'(fault), 32'(pq[i] == 15));
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1; mem_ready = 1'b0;
    @(posedge clk);
    #1 reset = 1'b0;
    chk("rst state", 32'(state), 32'd0);
    chk("rst fault", 32'(fault), 32'd0);
    chk("rst ctrl", 32'(ctrl), 32'(exp_ctrl(0, 1'b0, zero)));
  endtask

  task automatic hold_illegal(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      mem_ready = 1'($urandom); #1;
      chk("illegal hold state", 32'(state), 32'd15);
      chk("illegal hold fault", 32'(fault), 32'd1);
      chk("illegal hold ctrl", 32'(ctrl), 32'd0);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [5:0] legal [8] = '{6'd0, 6'd1, 6'd2, 6'd3, 6'd4, 6'd5, 6'd7, 6'd8};
    logic [5:0] op, fn;
    reset = 1'b1; opcode = '0; functi = '0; zero = 1'b0; mem_ready = 1'b0;
    do_reset();

    // Directed instruction paths.
    run_instr(6'd3, 6'd0, 0, 0, 2);          // ADDI
    run_instr(6'd1, 6'd0, 0, 3, 2);          // LW, 3 stalls in MEMRD
    run_instr(6'd5, 6'd0, 0, 0, 1);          // BEQ taken
    run_instr(6'd5, 6'd0, 0, 0, 0);          // BEQ not taken
    run_instr(6'd8, 6'd0, 0, 0, 2);          // JAL
    run_instr(6'd0, 6'b001000, 0, 0, 2);     // JR
    run_instr(6'd0, 6'b000111, 0, 0, 2);     // R-type
    run_instr(6'd2, 6'd0, 1, 2, 2);          // SW with stalls
    run_instr(6'd7, 6'd0, 0, 0, 2);          // J
    run_instr(6'd4, 6'd0, 0, 0, 2);          // SUBI
    // Ready on the last permitted cycle still proceeds.
    run_instr(6'd3, 6'd0, 15, 0, 2);
    run_instr(6'd1, 6'd0, 0, 15, 2);
    run_instr(6'd2, 6'd0, 0, 15, 2);

    // Random legal instruction stream.
    for (int k = 0; k < 80; k++) begin
      op = legal[$urandom_range(0, 7)];
      fn = ($urandom_range(0, 3) == 0) ? 6'b001000 : 6'($urandom);
      run_instr(op, fn, $urandom_range(0, 3), $urandom_range(0, 3), 2);
    end

    // Illegal opcodes: fault holds until reset.
    run_instr(6'b101010, 6'd0, 0, 0, 2);
    hold_illegal(20);
    do_reset();
    run_instr(6'b000110, 6'd0, 0, 0, 2);
    hold_illegal(3);
    do_reset();

    // Memory timeouts in FETCH, MEMRD and MEMWR.
    run_instr(6'd3, 6'd0, 16, 0, 2);
    hold_illegal(2);
    do_reset();
    run_instr(6'd1, 6'd0, 0, 16, 2);
    hold_illegal(2);
    do_reset();
    run_instr(6'd2, 6'd0, 0, 16, 2);
    hold_illegal(2);
    do_reset();

    // Reset in the middle of a MEMWR stall.
    opcode = 6'd2; functi = '0;
    @(negedge clk); mem_ready = 1'b1; #1 chk("mwr s0", 32'(state), 32'd0);
    @(negedge clk); #1 chk("mwr s1", 32'(state), 32'd1);
    @(negedge clk); #1 chk("mwr s2", 32'(state), 32'd2);
    @(negedge clk); mem_ready = 1'b0; #1 chk("mwr s5", 32'(state), 32'd5);
    chk("mwr memwrite", 32'(memory_write), 32'd1);
    @(negedge clk); reset = 1'b1; #1 chk("mwr stall", 32'(state), 32'd5);
    @(negedge clk); reset = 1'b0; #1;
    chk("mwr rst state", 32'(state), 32'd0);
    chk("mwr rst memwrite", 32'(memory_write), 32'd0);
    chk("mwr rst regwrite", 32'(register_write), 32'd0);
    chk("mwr rst fault", 32'(fault), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
